// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor.
//   ctr_t            2-bit saturating direction counter encoding
//   CTR_RESET        counter value after reset
//   CTR_ALLOC        counter value given to a newly allocated branch
//   ctr_inc/ctr_dec  saturating increment / decrement
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not-taken
    CTR_WNT = 2'b01,  // weakly not-taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// bp_pht: array of 2-bit saturating counters with one combinational read
// port and one synchronous update port. Holds the per-entry counters in
// the default build and the gshare pattern history table otherwise.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (counters -> 01)
//   rd_idx       read index; rd_ctr is the counter at that index
//   upd_en       apply an update at upd_idx this cycle
//   upd_alloc    load CTR_ALLOC instead of stepping the counter
//   upd_taken    step direction when not allocating
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_alloc,
  input  logic             upd_taken
);

  ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_en) begin
      if (upd_alloc)      ctr_q[upd_idx] <= CTR_ALLOC;
      else if (upd_taken) ctr_q[upd_idx] <= ctr_inc(ctr_q[upd_idx]);
      else                ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
    end
  end

  // Read is combinational: same-cycle updates are not bypassed.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters.
// Lookup is combinational on if_pc; resolved branches update the tables
// on the rising clock edge (visible the following cycle).
// Configuration macro: BP_GSHARE_EN -- counters move to a gshare PHT
//   indexed by (pc index XOR global history); GHR shifts on every update.
// Ports:
//   Clock, Resetn               clock, asynchronous active-low reset
//   if_pc                       fetch PC to predict
//   pred_hit/taken/target/hist  prediction and GHR snapshot
//   upd_valid/pc/taken/target   resolved conditional branch
//   upd_hist                    pred_hist that travelled with the branch
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned HIST_W  = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic [HIST_W-1:0] upd_hist
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx, pht_rd_idx, pht_up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  ctr_t             lk_ctr;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // BTB: taken branches allocate on miss or refresh the target on hit;
  // not-taken branches never touch the BTB.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= upd_target;
    end
  end

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;
  logic              unused;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)        ghr_q <= '0;
    else if (upd_valid) ghr_q <= (ghr_q << 1) | HIST_W'(upd_taken);
  end

  assign pht_rd_idx = lk_idx ^ IDX_W'(ghr_q);
  assign pht_up_idx = up_idx ^ IDX_W'(upd_hist);
  assign pred_hist  = ghr_q;
  assign unused     = ^{if_pc[1:0], upd_pc[1:0]};
`else
  logic unused;

  assign pht_rd_idx = lk_idx;
  assign pht_up_idx = up_idx;
  assign pred_hist  = '0;
  assign unused     = ^{if_pc[1:0], upd_pc[1:0], upd_hist};
`endif

  // Counters step on a BTB hit, load weakly-taken on a taken miss, and
  // are left alone on a not-taken miss.
  bp_pht #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_pht (
    .clk       (Clock),
    .rst_n     (Resetn),
    .rd_idx    (pht_rd_idx),
    .rd_ctr    (lk_ctr),
    .upd_en    (upd_valid && (up_hit || upd_taken)),
    .upd_idx   (pht_up_idx),
    .upd_alloc (!up_hit),
    .upd_taken (upd_taken)
  );

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && lk_ctr[1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : if_pc + PC_W'(4);

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned HIST_W = 4;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic [PC_W-1:0]   if_pc;
  logic              pred_hit, pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid, upd_taken;
  logic [PC_W-1:0]   upd_pc, upd_target;
  logic [HIST_W-1:0] upd_hist;

  int errors = 0;
  int checks = 0;

  branch_predictor #(
    .PC_W    (PC_W),
    .ENTRIES (16),
    .HIST_W  (HIST_W)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .if_pc       (if_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_hist   (pred_hist),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_hist    (upd_hist)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic upd(input logic [PC_W-1:0] pc, input logic tk,
                     input logic [PC_W-1:0] tgt, input logic [HIST_W-1:0] h);
    upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_hist = h;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [PC_W-1:0] pc,
                      input logic hit, input logic tk, input logic [PC_W-1:0] tgt);
    if_pc = pc;
    #1;
    check({tag, ".hit"},    64'(pred_hit),    64'(hit));
    check({tag, ".taken"},  64'(pred_taken),  64'(tk));
    check({tag, ".target"}, 64'(pred_target), 64'(tgt));
  endtask

  initial begin
    Resetn = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_hist = '0;
    if_pc = 32'h40;
    #2;
    look("in_reset", 32'h40, 1'b0, 1'b0, 32'h44);
    check("in_reset.hist", 64'(pred_hist), 64'h0);
    step(); step();
    Resetn = 1'b1;
    look("post_reset", 32'h40, 1'b0, 1'b0, 32'h44);

`ifdef BP_GSHARE_EN
    upd(32'h40, 1'b1, 32'h80, 4'b0000);   // alloc, PHT[0]=10, ghr=0001
    check("gs.hist1", 64'(pred_hist), 64'h1);
    upd(32'h40, 1'b0, 32'h0,  4'b0001);   // PHT[1] 01->00, ghr=0010
    upd(32'h40, 1'b1, 32'h80, 4'b0010);   // PHT[2] 01->10, ghr=0101
    check("gs.hist3", 64'(pred_hist), 64'h5);
    // lookup of index 0 reads PHT[0^5]=PHT[5], still at reset value 01
    look("gs.idx5", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h200, 1'b0, 32'h0, 4'b0101);   // not-taken miss still shifts
    check("gs.miss_shift", 64'(pred_hist), 64'hA);
    // ghr=1010 -> index 0 reads PHT[10], still 01
    look("gs.idxA", 32'h40, 1'b1, 1'b0, 32'h44);
`else
    // same-cycle lookup sees pre-update contents
    upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80; upd_hist = 4'hF;
    upd_valid = 1'b1;
    look("same_cycle", 32'h40, 1'b0, 1'b0, 32'h44);
    step();
    upd_valid = 1'b0;
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h80);
    check("hist_zero", 64'(pred_hist), 64'h0);

    upd(32'h40, 1'b0, 32'h0, 4'h0);      // 10 -> 01
    look("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 4'h0);      // 01 -> 00
    look("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 4'h0);      // saturate at 00
    look("nt3", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h90, 4'h0);     // 00 -> 01
    look("t1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h90, 4'h0);     // 01 -> 10, target rewritten
    look("t2", 32'h40, 1'b1, 1'b1, 32'h90);
    upd(32'h40, 1'b1, 32'h90, 4'h0);     // 10 -> 11
    upd(32'h40, 1'b1, 32'h90, 4'h0);     // saturate at 11
    upd(32'h40, 1'b0, 32'h0, 4'h0);      // 11 -> 10, still taken
    look("sat_hi", 32'h40, 1'b1, 1'b1, 32'h90);
    upd(32'h40, 1'b0, 32'h0, 4'h0);      // 10 -> 01
    look("sat_hi2", 32'h40, 1'b1, 1'b0, 32'h44);

    step(); step();                       // idle cycles keep state
    look("idle", 32'h40, 1'b1, 1'b0, 32'h44);

    upd(32'h100, 1'b0, 32'h0, 4'h0);     // not-taken miss on same index
    look("nt_miss_keep", 32'h40, 1'b1, 1'b0, 32'h44);
    look("nt_miss_none", 32'h100, 1'b0, 1'b0, 32'h104);

    upd(32'h440, 1'b1, 32'h500, 4'h0);   // alias replaces 0x40
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new", 32'h440, 1'b1, 1'b1, 32'h500);

    upd(32'h44, 1'b1, 32'h1000, 4'h0);
    look("idx1", 32'h44, 1'b1, 1'b1, 32'h1000);
    look("idx0_kept", 32'h440, 1'b1, 1'b1, 32'h500);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
`endif

    // reset mid-stream with an update pending
    upd_pc = 32'h48; upd_taken = 1'b1; upd_target = 32'h2000; upd_hist = 4'h0;
    upd_valid = 1'b1;
    #1;
    Resetn = 1'b0;
    #1;
    check("rst_async.hist", 64'(pred_hist), 64'h0);
    look("rst_async", 32'h440, 1'b0, 1'b0, 32'h444);
    step();
    upd_valid = 1'b0;
    step();
    Resetn = 1'b1;
    look("rst_lost", 32'h48, 1'b0, 1'b0, 32'h4C);
    look("rst_cleared", 32'h40, 1'b0, 1'b0, 32'h44);
    check("rst_ghr", 64'(pred_hist), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
